// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART Rx FSM.
// A falling edge of rx_busy marks end-of-frame and pushes rx_data into a
// first-word-fall-through FIFO. The block also keeps a sticky overflow flag
// and reports the fill level.
// Optional feature macro: UART_RX_FIFO_THRESH_EN adds the THRESH parameter
// and a registered irq_thresh output (level >= THRESH).
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    parameter int THRESH = DEPTH / 2
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_busy,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    input  logic              clr_ovf,
    input  logic              flush
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    output logic              irq_thresh
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              busy_q;
    logic              armed_q;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, valid_q;
    logic              ovf_q, ovf_d;

    logic eof, pop, push, ovf_set;

    // armed only qualifies after rx_busy has been seen low, so a frame that
    // was already running when reset released never produces an eof.
    assign eof     = armed_q & busy_q & ~rx_busy;
    assign pop     = valid_q & rd_ready;
    assign push    = eof & (~full_q | pop) & ~flush;
    assign ovf_set = eof & full_q & ~pop & ~flush;

    // Next-state for pointers, level and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // A same-cycle overflow event beats the clear.
        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    // Frame-edge tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            busy_q  <= rx_busy;
            armed_q <= armed_q | ~rx_busy;
        end
    end

    // FIFO control registers; full/valid are derived from the next level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == DEPTH_L);
            valid_q  <= (level_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    // Storage; cleared on reset so rd_data reads 8'h00 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = valid_q;
    assign level    = level_q;
    assign full     = full_q;
    assign overflow = ovf_q;

`ifdef UART_RX_FIFO_THRESH_EN
    localparam logic [ADDR_W:0] THRESH_L = (ADDR_W + 1)'(THRESH);
    logic irq_q;

    // Threshold flag computed from the next level so it lines up with level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     irq_q <= 1'b0;
        else if (flush) irq_q <= 1'b0;
        else            irq_q <= (level_d >= THRESH_L);
    end

    assign irq_thresh = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int THRESH = DEPTH / 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_busy = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overflow;
    logic              clr_ovf = 1'b0;
    logic              flush = 1'b0;
`ifdef UART_RX_FIFO_THRESH_EN
    logic              irq_thresh;
`endif

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_busy(rx_busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .level(level), .full(full), .overflow(overflow),
        .clr_ovf(clr_ovf), .flush(flush)
`ifdef UART_RX_FIFO_THRESH_EN
        , .irq_thresh(irq_thresh)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: contents as a queue, plus frame-edge bookkeeping
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_armed;
    bit         m_prev_busy;
    bit         rand_mode = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf       = 0;
        m_armed     = 0;
        m_prev_busy = 0;
    endtask

    task automatic model_step();
        bit eof, pop;
        eof = m_armed && m_prev_busy && !rx_busy;
        pop = (m_q.size() != 0) && rd_ready;
        if (clr_ovf) m_ovf = 0;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (eof) begin
                if (m_q.size() < DEPTH) m_q.push_back(rx_data);
                else                    m_ovf = 1;
            end
        end
        m_prev_busy = rx_busy;
        if (!rx_busy) m_armed = 1;
    endtask

    task automatic compare_all();
        chk("rd_valid", rd_valid, m_q.size() != 0);
        chk("level", level, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
`ifdef UART_RX_FIFO_THRESH_EN
        chk("irq_thresh", irq_thresh, m_q.size() >= THRESH);
`endif
    endtask

    // one clock: randomize controls if requested, advance model, check after edge
    task automatic tick();
        if (rand_mode) begin
            rd_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 59) == 0);
            clr_ovf  = ($urandom_range(0, 19) == 0);
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_data", rd_data, 8'h00);
`ifdef UART_RX_FIFO_THRESH_EN
        chk("rst_irq", irq_thresh, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // one Rx frame: busy high for len cycles, eof cycle, then idle gap
    task automatic frame(input logic [7:0] b, input int len, input int gap,
                         input bit rdy_eof, input bit flush_eof);
        bit save_rdy;
        rx_data = b;
        rx_busy = 1'b1;
        repeat (len) tick();
        rx_busy  = 1'b0;
        save_rdy = rd_ready;
        if (!rand_mode) begin
            if (rdy_eof)   rd_ready = 1'b1;
            if (flush_eof) flush = 1'b1;
        end
        tick();
        if (!rand_mode) begin
            rd_ready = save_rdy;
            flush    = 1'b0;
        end
        repeat (gap) tick();
    endtask

    initial begin
        do_reset();
        repeat (2) tick();

        // two frames held, then drained in order
        frame(8'hA5, 5, 1, 0, 0);
        chk("t1_head", rd_data, 8'hA5);
        frame(8'h3C, 5, 2, 0, 0);
        chk("t1_level", level, 2);
        rd_ready = 1'b1;
        repeat (4) tick();
        rd_ready = 1'b0;
        chk("t2_empty", rd_valid, 0);

        // overfill: 17 frames, last one dropped
        for (int i = 0; i < 17; i++) frame(8'(i), 3, 1, 0, 0);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 1);
        rd_ready = 1'b1;
        repeat (20) tick();
        rd_ready = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_clr", overflow, 0);

        // full FIFO with pop coincident with eof
        for (int i = 0; i < 16; i++) frame(8'(8'h40 + i), 2, 1, 0, 0);
        frame(8'h77, 3, 1, 1, 0);
        chk("t4_level", level, 16);
        chk("t4_ovf", overflow, 0);
        rd_ready = 1'b1;
        repeat (20) tick();
        rd_ready = 1'b0;

        // reset in the middle of a frame
        rx_data = 8'hEE;
        rx_busy = 1'b1;
        repeat (3) tick();
        do_reset();
        repeat (3) tick();
        rx_busy = 1'b0;
        repeat (2) tick();
        chk("t5_nopush", rd_valid, 0);
        frame(8'h5A, 4, 1, 0, 0);
        chk("t5_push", rd_data, 8'h5A);
        rd_ready = 1'b1;
        repeat (2) tick();
        rd_ready = 1'b0;

        // flush coincident with eof, then threshold crossing
        for (int i = 0; i < 5; i++) frame(8'(8'h90 + i), 2, 1, 0, 0);
        frame(8'hF0, 2, 1, 0, 0);
        frame(8'hF1, 2, 1, 0, 1);
        chk("t6_level", level, 0);
        for (int i = 0; i < 9; i++) frame(8'(8'hB0 + i), 2, 1, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 90; i++) begin
            frame(8'($urandom), $urandom_range(1, 10), $urandom_range(0, 3), 0, 0);
            if (i == 45) begin
                rx_busy = 1'b1;
                tick();
                do_reset();
                repeat (2) tick();
                rx_busy = 1'b0;
                tick();
            end
        end
        rand_mode = 0;
        rd_ready  = 1'b1;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
